// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares RAM port A between two requesters with one access per cycle.
// Requesters take turns round-robin. Read data returns to the right requester
// one cycle after its read is granted.
// A write is held off for one cycle after a granted read. Without this, the
// RAM write-through path would overwrite the read data on ram_qA.
// Optional feature macro: RAM_ARB_LOCK_EN adds lock0/lock1 and the LOCK0/LOCK1
// states, so a requester can keep the port for a burst.
//
// Handshake: requester N's access is accepted in a cycle when reqN && gntN.
// gntN is combinational and depends only on inputs and registered state.
// Requester N may change its request after acceptance.
// A read accepted in cycle T returns exactly once, in cycle T+1,
// as rvalidN = 1 with rdataN valid. There is no backpressure on the return.
module ram_port_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic                     req1,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [ADDRESS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0]    data0,
  input  logic [DATA_WIDTH-1:0]    data1,
`ifdef RAM_ARB_LOCK_EN
  input  logic                     lock0,
  input  logic                     lock1,
`endif
  output logic                     gnt0,
  output logic                     gnt1,
  output logic                     rvalid0,
  output logic                     rvalid1,
  output logic [DATA_WIDTH-1:0]    rdata0,
  output logic [DATA_WIDTH-1:0]    rdata1,
  output logic [ADDRESS_WIDTH-1:0] ram_addrA,
  output logic [DATA_WIDTH-1:0]    ram_dataA,
  output logic                     ram_weA,
  input  logic [DATA_WIDTH-1:0]    ram_qA,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  // Requester of the most recent accepted access (1 after reset, so 0 wins first tie)
  logic r_last;
  // A read was accepted last cycle; its data is on ram_qA this cycle
  logic r_ret_pend;
  // Which requester that pending read belongs to
  logic r_ret_id;

  // Lock currently held by requester N (state LOCKn and lockN still high)
  logic w_hold0;
  logic w_hold1;
  logic w_elig0;
  logic w_elig1;
  logic w_acc_read;

`ifdef RAM_ARB_LOCK_EN
  state_t r_state;

  assign w_hold0     = (r_state == ST_LOCK0) && lock0;
  assign w_hold1     = (r_state == ST_LOCK1) && lock1;
  assign o_dbg_state = r_state;

  // Lock FSM: enter LOCKn when n is accepted with lockN; leave on the first cycle lockN drops.
  // On the release cycle normal arbitration applies, so the other requester may lock immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ARB;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (gnt0 && lock0)      r_state <= ST_LOCK0;
          else if (gnt1 && lock1) r_state <= ST_LOCK1;
        end
        ST_LOCK0: begin
          if (!lock0) r_state <= (gnt1 && lock1) ? ST_LOCK1 : ST_ARB;
        end
        ST_LOCK1: begin
          if (!lock1) r_state <= (gnt0 && lock0) ? ST_LOCK0 : ST_ARB;
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end
`else
  assign w_hold0     = 1'b0;
  assign w_hold1     = 1'b0;
  assign o_dbg_state = ST_ARB;
`endif

  // A write is blocked while a read return occupies ram_qA; the other requester is blocked during a lock
  assign w_elig0 = req0 && !(we0 && r_ret_pend) && !w_hold1;
  assign w_elig1 = req1 && !(we1 && r_ret_pend) && !w_hold0;

  // Round-robin grant: on a tie the requester that did not go last wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (w_elig0 && w_elig1) begin
        gnt0 = r_last;
        gnt1 = !r_last;
      end else begin
        gnt0 = w_elig0;
        gnt1 = w_elig1;
      end
    end
  end

  // Steer the winner onto port A; idle port is driven to all zeros
  always_comb begin
    ram_addrA = '0;
    ram_dataA = '0;
    ram_weA   = 1'b0;
    if (gnt0) begin
      ram_addrA = addr0;
      ram_dataA = data0;
      ram_weA   = we0;
    end else if (gnt1) begin
      ram_addrA = addr1;
      ram_dataA = data1;
      ram_weA   = we1;
    end
  end

  assign w_acc_read = (gnt0 && !we0) || (gnt1 && !we1);

  // Round-robin history and read-return bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= 1'b1;
      r_ret_pend <= 1'b0;
      r_ret_id   <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        r_last <= gnt1;
      end
      r_ret_pend <= w_acc_read;
      if (w_acc_read) begin
        r_ret_id <= gnt1;
      end
    end
  end

  // Return path: gated by rst so a read accepted just before reset is dropped
  assign rvalid0 = !rst && r_ret_pend && !r_ret_id;
  assign rvalid1 = !rst && r_ret_pend &&  r_ret_id;
  assign rdata0  = rvalid0 ? ram_qA : '0;
  assign rdata1  = rvalid1 ? ram_qA : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: RAM model with registered reads and
// write-through, plus a behavioural reference model with a shadow memory and
// an expected-read-data queue. Lock scenarios run when RAM_ARB_LOCK_EN is defined.
module tb_ram_port_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
`ifdef RAM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic          lock0, lock1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] ram_addrA;
  logic [DW-1:0] ram_dataA;
  logic          ram_weA;
  logic [DW-1:0] ram_qA;
  logic [1:0]    dbg_state;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
`ifdef RAM_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_addrA(ram_addrA), .ram_dataA(ram_dataA), .ram_weA(ram_weA),
    .ram_qA(ram_qA), .o_dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM port A model ----------------
  logic [DW-1:0] ram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_q_r;
  always @(posedge clk) begin
    if (ram_weA) ram_mem[ram_addrA] <= ram_dataA;
    ram_q_r <= ram_mem[ram_addrA];
  end
  assign ram_qA = ram_weA ? ram_dataA : ram_q_r;

  // ---------------- reference model state / scoreboard ----------------
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  logic [DW-1:0] exp_q [$];
  int m_last;
  int m_pend;
  int m_id;
  int m_owner;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, check outputs, advance the model
  task automatic step(input logic r,
                      input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic l0, input logic l1);
    logic          rq [2];
    logic          wr [2];
    logic          lk [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] dt [2];
    logic          elig [2];
    logic          e_rv [2];
    logic [DW-1:0] e_rd [2];
    logic [DW-1:0] val;
    int locked_to;
    int win;
    @(negedge clk);
    rst = r; req0 = q0; we0 = w0; addr0 = a0; data0 = d0;
    req1 = q1; we1 = w1; addr1 = a1; data1 = d1; lock0 = l0; lock1 = l1;
    #1;
    rq[0] = q0; rq[1] = q1; wr[0] = w0; wr[1] = w1;
    ad[0] = a0; ad[1] = a1; dt[0] = d0; dt[1] = d1;
    lk[0] = LOCK_EN && l0; lk[1] = LOCK_EN && l1;
    locked_to = (m_owner >= 0 && lk[m_owner]) ? m_owner : -1;
    for (int i = 0; i < 2; i++)
      elig[i] = rq[i] && !(wr[i] && m_pend != 0) && (locked_to < 0 || locked_to == i);
    if (r)                        win = -1;
    else if (elig[0] && elig[1])  win = 1 - m_last;
    else if (elig[0])             win = 0;
    else if (elig[1])             win = 1;
    else                          win = -1;
    e_rv[0] = 1'b0; e_rv[1] = 1'b0; e_rd[0] = '0; e_rd[1] = '0;
    if (m_pend != 0) begin
      val = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      if (!r) begin
        e_rv[m_id] = 1'b1;
        e_rd[m_id] = val;
      end
    end
    check("gnt0",      gnt0,      (win == 0));
    check("gnt1",      gnt1,      (win == 1));
    check("ram_weA",   ram_weA,   (win >= 0) ? wr[win] : 1'b0);
    check("ram_addrA", ram_addrA, (win >= 0) ? ad[win] : '0);
    check("ram_dataA", ram_dataA, (win >= 0) ? dt[win] : '0);
    check("rvalid0",   rvalid0,   e_rv[0]);
    check("rvalid1",   rvalid1,   e_rv[1]);
    check("rdata0",    rdata0,    e_rd[0]);
    check("rdata1",    rdata1,    e_rd[1]);
    if (r) begin
      m_last = 1; m_pend = 0; m_owner = -1;
    end else begin
      m_pend = 0;
      if (win >= 0) begin
        m_last = win;
        if (wr[win]) begin
          shadow[ad[win]] = dt[win];
        end else begin
          exp_q.push_back(shadow[ad[win]]);
          m_pend = 1;
          m_id = win;
        end
      end
      if (locked_to < 0) m_owner = (win >= 0 && lk[win]) ? win : -1;
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] v;
    n_checks = 0; n_errors = 0;
    m_last = 1; m_pend = 0; m_id = 0; m_owner = -1;
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; lock0 = 0; lock1 = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      v = DW'($urandom);
      ram_mem[i] = v;
      shadow[i]  = v;
    end

    // reset with active requests: no grant, port idle
    step(1'b1, 1'b1, 1'b1, 8'h01, 8'h11, 1'b1, 1'b0, 8'h02, 8'h22, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h01, 8'h11, 1'b1, 1'b1, 8'h02, 8'h22, 1'b0, 1'b0);

    // both read 0x10 / 0x20: 0 first, then alternate every cycle
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0);
    idle(1'b0);

    // write 0xA5 to 0x33 by requester 0, then read back by requester 1
    step(1'b0, 1'b1, 1'b1, 8'h33, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b0);
    idle(1'b0);

    // read by 0, then write by 1 is held off one cycle and read data stays intact
    step(1'b0, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h44, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h44, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    idle(1'b0);

    // reset right after an accepted read: return dropped, then tie goes to 0
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'h56, 8'h00, 1'b1, 1'b0, 8'h57, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h56, 8'h00, 1'b1, 1'b0, 8'h57, 8'h00, 1'b0, 1'b0);
    idle(1'b0);

    if (LOCK_EN) begin
      // requester 1 holds the port for 4 cycles while 0 waits; released in cycle 5
      step(1'b0, 1'b1, 1'b0, 8'h60, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
        step(1'b0, 1'b1, 1'b0, 8'h61, 8'h00, 1'b1, 1'b0, 8'h70 + 8'(i), 8'h00, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 8'h62, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      idle(1'b0);
    end

    // idle for 3 cycles: port quiet, no returns
    for (int i = 0; i < 3; i++) idle(1'b0);

    // randomized traffic on a small address window to exercise hazards
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 15)), DW'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           AW'($urandom_range(0, 15)), DW'($urandom),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 3));
    end
    idle(1'b0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single read/write port (port A) of the team's dual-port block RAM between two requesters, e.g. a line-buffer writer and a CPU/config read-back path. Port B stays dedicated to the read-only consumer and is not touched by this block. The block does three things: it arbitrates one access per cycle round-robin, it steers the winner's address, data and write-enable onto port A, and it returns read data to the correct requester one cycle later. It also prevents the port A write-through path from corrupting a pending read return.

## Interface
- DATA_WIDTH, 8, RAM word width
- ADDRESS_WIDTH, 8, RAM address width
- clk  in  1  single clock for the block and the RAM
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request from requester 0 / 1
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0 / addr1  in  ADDRESS_WIDTH  access address
- data0 / data1  in  DATA_WIDTH  write data
- lock0 / lock1  in  1  hold grant over subsequent cycles; present only with RAM_ARB_LOCK_EN
- gnt0 / gnt1  out  1  combinational grant; access accepted when reqN && gntN
- rvalid0 / rvalid1  out  1  read data valid, one-cycle pulse
- rdata0 / rdata1  out  DATA_WIDTH  read data; meaningful only while rvalidN = 1
- ram_addrA  out  ADDRESS_WIDTH  to RAM port A address
- ram_dataA  out  DATA_WIDTH  to RAM port A write data
- ram_weA  out  1  to RAM port A write enable
- ram_qA  in  DATA_WIDTH  from RAM port A. The RAM registers reads with 1-cycle latency. While ram_weA = 1 the RAM shows ram_dataA on this input (write-through).

## Operation
- One accepted access per cycle at most; gnt0 and gnt1 are never both 1.
- Round-robin:
  - A register `last` records the requester of the most recent accepted access.
  - When both requesters are eligible, the one not equal to `last` wins.
  - A single eligible requester always wins.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- Read-return slot:
  - An accepted read at cycle T sets `ret_pend` and `ret_id` for cycle T+1.
  - At T+1, write requests are ineligible (gnt = 0 for reqN && weN).
  - Read requests at T+1 remain eligible, so back-to-back reads proceed at full rate.
- Port steering:
  - With a grant: ram_addrA/ram_dataA/ram_weA = the granted requester's addr/data/(we).
  - With no grant: ram_addrA = 0, ram_dataA = 0, ram_weA = 0.
- Read return: at T+1, rvalid[ret_id] = 1 and rdata[ret_id] = ram_qA. The other rvalid stays 0. Accepted writes produce no rvalid.
- rdataN is zero whenever rvalidN = 0.
- State machine, with RAM_ARB_LOCK_EN only: ARB, LOCK0, LOCK1.
  - ARB → LOCKn: requester n is accepted with lockn = 1.
  - In LOCKn: only requester n is eligible; the read-return write block still applies.
  - LOCKn → ARB: the first cycle in which lockn = 0, whether or not n requests. Normal arbitration applies in that same cycle.
- Reset (including mid-operation):
  - gnt0/1 = 0 and ram_weA = 0 while rst = 1.
  - Next state: state = ARB, last = 1, ret_pend = 0, rvalid0/1 = 0, rdata0/1 = 0.
  - A read accepted in the cycle before rst asserts is dropped; no rvalid.

## Timing
- Grant latency: 0 cycles (combinational from reqN, weN, state, `last`, ret_pend).
- Read latency: rvalid exactly 1 cycle after acceptance; no buffering. Requesters must consume rdata in that cycle.
- Write latency: data is in the RAM at the clock edge ending the accepted cycle. A read of the same address on the next cycle returns the new data.
- Maximum throughput: 1 access/cycle. A write following a read always loses exactly one cycle.
- Registered state: `last`, state, ret_pend, ret_id. No other flops.

## Configuration
- RAM_ARB_LOCK_EN defined:
  - lock0/lock1 ports exist.
  - The LOCK0/LOCK1 states are implemented; used for bursts that must not interleave.
- RAM_ARB_LOCK_EN undefined:
  - lock ports are absent.
  - The state is permanently ARB; pure round-robin.

## Test plan
- Reset, then req0 = req1 = 1 reads of addr 0x10 / 0x20 → gnt0 first. rvalid0 next cycle with the RAM word at 0x10, then gnt1 and rvalid1 with the word at 0x20; alternation continues every cycle.
- req0 write 0xA5 to 0x33, then req1 read 0x33 → rvalid1 one cycle after the read grant, rdata1 = 0xA5.
- Read by requester 0 at T, write request from requester 1 at T+1 → gnt1 = 0 at T+1, rdata0 equals the RAM content (not data1), gnt1 = 1 at T+2.
- rst asserted the cycle after an accepted read → no rvalid. After release, `last` = 1 and the first tie goes to requester 0.
- RAM_ARB_LOCK_EN: requester 1 accepted with lock1 = 1 for 4 cycles while req0 = 1 → gnt0 = 0 for all 4. lock1 = 0 in cycle 5 → gnt0 = 1 in cycle 5.
- Neither requester active for 3 cycles → ram_weA = 0, ram_addrA = 0, rvalid0 = rvalid1 = 0 throughout.
